// File: rtl/segment_uop_sequencer.sv
// Splits one segmented vector load/store into single-element micro-ops, keeping up to
// MaxOutstanding in flight; tracks in-order responses and reports the precise faulting segment.
module segment_uop_sequencer #(
  parameter int unsigned VlWidth        = 16,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_is_load_i,
  input  logic [1:0]           req_mode_i,
  input  logic [2:0]           req_nf_i,
  input  logic [1:0]           req_eew_i,
  input  logic [VlWidth-1:0]   req_vl_i,
  input  logic [VlWidth-1:0]   req_vstart_i,
  input  logic [4:0]           req_vd_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [AddrWidth-1:0] req_stride_i,
  output logic                 uop_valid_o,
  input  logic                 uop_ready_i,
  output logic [VlWidth-1:0]   uop_vstart_o,
  output logic [VlWidth-1:0]   uop_vl_o,
  output logic [4:0]           uop_vd_o,
  output logic [AddrWidth-1:0] uop_addr_o,
  output logic [AddrWidth-1:0] uop_stride_o,
  output logic                 uop_is_load_o,
  output logic                 uop_indexed_o,
  input  logic                 uop_resp_valid_i,
  input  logic                 uop_resp_exc_i,
  output logic                 resp_valid_o,
  output logic                 resp_exc_o,
  output logic [VlWidth-1:0]   resp_vstart_o,
  output logic                 load_complete_o,
  output logic                 store_complete_o,
  output logic                 busy_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

  state_e               r_state, w_state_nxt;
  logic                 r_is_load;
  logic [1:0]           r_mode;
  logic [2:0]           r_nf, r_fld, r_rsp_fld;
  logic [1:0]           r_eew;
  logic [VlWidth-1:0]   r_vl, r_seg, r_rsp_seg, r_fault_vstart;
  logic [4:0]           r_vd;
  logic [AddrWidth-1:0] r_addr, r_stride;
  logic [OutW-1:0]      r_outst;
  logic                 r_exc;

  logic                 w_accept, w_in_issue, w_can_issue, w_issue, w_rsp, w_new_exc;
  logic                 w_last_fld, w_last_uop, w_rsp_last_fld, w_indexed;
  logic [AddrWidth-1:0] w_unit_stride, w_stride;

  assign w_accept       = (r_state == IDLE) && req_valid_i;
  assign w_in_issue     = (r_state == ISSUE);
  assign w_can_issue    = w_in_issue && (r_outst < OutW'(MaxOutstanding));
  assign w_issue        = w_can_issue && uop_ready_i;
  // Responses only count while something is actually in flight, so stray ones never underflow.
  assign w_rsp          = uop_resp_valid_i && (r_state inside {ISSUE, DRAIN}) && (r_outst != '0);
  assign w_new_exc      = w_rsp && uop_resp_exc_i && !r_exc;
  assign w_last_fld     = (r_fld == r_nf);
  assign w_last_uop     = w_last_fld && (r_seg == r_vl - 1'b1);
  assign w_rsp_last_fld = (r_rsp_fld == r_nf);
  assign w_indexed      = (r_mode == 2'd2);
  assign w_unit_stride  = AddrWidth'({1'b0, r_nf} + 4'd1) << r_eew;
  assign w_stride       = w_indexed ? '0 : ((r_mode == 2'd0) ? w_unit_stride : r_stride);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (req_valid_i) w_state_nxt = (req_vstart_i >= req_vl_i) ? RESP : ISSUE;
      ISSUE:   if (w_new_exc || (w_issue && w_last_uop)) w_state_nxt = DRAIN;
      DRAIN:   if ((r_outst == '0) || ((r_outst == OutW'(1)) && w_rsp)) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_is_load <= 1'b0; r_mode <= '0; r_nf <= '0; r_eew <= '0; r_vl <= '0; r_vd <= '0;
      r_addr <= '0; r_stride <= '0; r_seg <= '0; r_fld <= '0; r_rsp_seg <= '0;
      r_rsp_fld <= '0; r_outst <= '0; r_exc <= 1'b0; r_fault_vstart <= '0;
    end else if (w_accept) begin
      r_is_load <= req_is_load_i; r_mode <= req_mode_i; r_nf <= req_nf_i; r_eew <= req_eew_i;
      r_vl <= req_vl_i; r_vd <= req_vd_i; r_addr <= req_addr_i; r_stride <= req_stride_i;
      r_seg <= req_vstart_i; r_fld <= '0; r_rsp_seg <= req_vstart_i; r_rsp_fld <= '0;
      r_outst <= '0; r_exc <= 1'b0; r_fault_vstart <= '0;
    end else if (r_state == RESP) begin
      r_seg <= '0; r_fld <= '0; r_rsp_seg <= '0; r_rsp_fld <= '0;
      r_outst <= '0; r_exc <= 1'b0; r_fault_vstart <= '0;
    end else begin
      if (w_issue) begin
        if (w_last_fld) begin
          r_fld <= '0;
          r_seg <= r_seg + 1'b1;
        end else begin
          r_fld <= r_fld + 1'b1;
        end
      end
      // Response counters mirror issue order, so they name the segment each response belongs to.
      if (w_rsp) begin
        if (w_rsp_last_fld) begin
          r_rsp_fld <= '0;
          r_rsp_seg <= r_rsp_seg + 1'b1;
        end else begin
          r_rsp_fld <= r_rsp_fld + 1'b1;
        end
      end
      if (w_new_exc) begin
        r_exc          <= 1'b1;
        r_fault_vstart <= r_rsp_seg;
      end
      if (w_issue && !w_rsp)      r_outst <= r_outst + 1'b1;
      else if (!w_issue && w_rsp) r_outst <= r_outst - 1'b1;
    end
  end

  assign req_ready_o      = (r_state == IDLE);
  assign busy_o           = (r_state != IDLE);
  assign uop_valid_o      = w_can_issue;
  assign uop_vstart_o     = w_in_issue ? r_seg : '0;
  assign uop_vl_o         = w_in_issue ? r_seg + 1'b1 : '0;
  assign uop_vd_o         = w_in_issue ? r_vd + 5'(r_fld) : '0;
  assign uop_addr_o       = w_in_issue ? r_addr + (AddrWidth'(r_fld) << r_eew) : '0;
  assign uop_stride_o     = w_in_issue ? w_stride : '0;
  assign uop_is_load_o    = w_in_issue && r_is_load;
  assign uop_indexed_o    = w_in_issue && w_indexed;
  assign resp_valid_o     = (r_state == RESP);
  assign resp_exc_o       = resp_valid_o && r_exc;
  assign resp_vstart_o    = (resp_valid_o && r_exc) ? r_fault_vstart : '0;
  assign load_complete_o  = resp_valid_o && r_is_load;
  assign store_complete_o = resp_valid_o && !r_is_load;

endmodule
